johnson_decoder: RTL and testbench
==================================

# johnson_decoder

Receive-side companion to the Johnson counter. Samples a WIDTH-bit Johnson code on qualified cycles and converts it to a binary state index. Flags codes that are not legal Johnson states and steps that are not the legal successor of the previous state. Maintains a lock FSM and a saturating error counter. Sits downstream of any Johnson-counted sequencer as a decoder and integrity monitor.

## Interface
- WIDTH, 4, Johnson code width (>= 2); the sequence has 2*WIDTH states. IW = $clog2(2*WIDTH).
- LOCK_COUNT, 3, consecutive in-sequence legal samples required to assert lock (1..15).

- clk  input  1  clock; all logic on rising edge.
- clear  input  1  reset, synchronous, active-low.
- code_valid  input  1  sample qualifier; one counter step per asserted cycle.
- code  input  WIDTH  Johnson code under test.
- index  output  IW  decoded state index of last legal sample.
- index_valid  output  1  one-cycle pulse: last sample legal.
- illegal  output  1  one-cycle pulse: last sample not a Johnson code.
- seq_error  output  1  one-cycle pulse: legal sample but wrong successor while locked.
- locked  output  1  level: lock FSM in LOCKED.
- err_count  output  8  saturating count of illegal + seq_error events.

## Operation
- Sequence (WIDTH=4), index 0..7: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
  - General rule: shift left, inverted MSB enters LSB.
- Legality:
  - code[WIDTH-1]=0: legal iff the ones occupy a contiguous LSB run (0...01...1 or all zeros); index = popcount(code).
  - code[WIDTH-1]=1: legal iff the ones occupy a contiguous MSB run (1...10...0 or all ones); index = WIDTH + number of zeros.
  - All 2^WIDTH - 2*WIDTH other codes are illegal.
- Successor: expected index = (prev + 1) mod 2*WIDTH. Wrap from 2*WIDTH-1 to 0 is legal. A repeated index is a sequence error.
- Internal state: FSM {UNLOCKED, LOCKED}, prev index, have_prev flag, run counter (4 bits).
- UNLOCKED, legal sample:
  - If have_prev and index == prev+1: run++. Otherwise run = 1 (new seed).
  - If run reaches LOCK_COUNT: go to LOCKED.
- UNLOCKED, illegal sample: run = 0, have_prev = 0, illegal pulse, err_count++.
- LOCKED, legal successor: stay LOCKED, index_valid pulse.
- LOCKED, legal non-successor:
  - seq_error pulse and index_valid pulse; index updates.
  - err_count++, go to UNLOCKED, run = 1, the sample seeds a new run.
- LOCKED, illegal: illegal pulse, err_count++, go to UNLOCKED, run = 0, have_prev = 0.
- In every state, a legal sample updates prev and index. An illegal sample leaves index unchanged.
- illegal and seq_error are never asserted together.
- err_count saturates at 255 and holds until reset.
- code_valid=0: all pulses 0; state, run, prev, index and err_count hold.

## Timing
- Reset: clear=0 sampled at a clk edge takes priority over code_valid. After that edge: index=0, index_valid=0, illegal=0, seq_error=0, locked=0, err_count=0. Internal: UNLOCKED, run=0, have_prev=0.
- Reset mid-operation discards lock and history immediately; no pulse is emitted for the sample present during reset.
- Latency: all outputs are registered and reflect a sample taken at edge N from edge N onward (visible the cycle after code_valid is presented).
- locked rises on the same edge as the index_valid pulse of the LOCK_COUNT-th in-sequence sample. locked falls on the same edge as the illegal or seq_error pulse that breaks lock.
- LOCK_COUNT=1: the first legal sample locks.
- Back-to-back code_valid every cycle is supported: throughput is one sample per clock.
- Gaps in code_valid do not break the sequence.

## Test plan
- Reset: clear=0 for 2 cycles with code_valid=1, code=0001 -> all outputs 0. Release and feed 0000 -> index=0, index_valid=1, locked=0.
- Lock and wrap: feed 0000, 0001, 0011 -> index 0, 1, 2; locked=1 after 0011. Continue through 1000 then 0000 -> index 7 then 0, no seq_error, err_count=0.
- Illegal: while locked, feed 0101 -> illegal=1, index_valid=0, index holds, locked=0, err_count=1. Then 0000, 0001, 0011 -> relock.
- Skip: locked at 0011 (index 2), feed 1111 -> seq_error=1, index=4, locked=0, err_count+1. Then 1110, 1100 -> locked=1 (run seeded at 4).
- Load jump from UNLOCKED: seed 1000 (index 7), then 0000, 0001 with idle cycles between -> wrap counts as successor; locked=1 after 0001. Assert clear=0 mid-run -> locked=0, err_count=0 on the next edge.
- Saturation: 300 consecutive illegal samples (1010) -> err_count stops at 255, illegal pulses every sample, locked stays 0.

Source files
------------

// File: rtl/johnson_decoder.sv
// johnson_decoder
//   Receive-side decoder and integrity monitor for a WIDTH-bit Johnson code.
//   Each qualified sample is converted to a state index (0 .. 2*WIDTH-1).
//   The block flags codes that are not Johnson states and, while locked,
//   legal codes that are not the successor of the previous one. Lock is
//   gained after LOCK_COUNT consecutive in-sequence legal samples.
//
// Ports
//   clk          clock, rising edge
//   clear        synchronous active-low reset, overrides code_valid
//   code_valid   sample qualifier
//   code         Johnson code under test
//   index        decoded index of the last legal sample
//   index_valid  pulse: last sample was legal
//   illegal      pulse: last sample was not a Johnson code
//   seq_error    pulse: legal sample, wrong successor while locked
//   locked       level: lock FSM in LOCKED
//   err_count    saturating count of illegal + seq_error events
//
// State table
//   UNLOCKED | building a run of in-sequence legal samples
//   LOCKED   | run reached LOCK_COUNT, every sample checked as successor
module johnson_decoder #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3,
  localparam int IW        = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             code_valid,
  input  logic [WIDTH-1:0] code,
  output logic [IW-1:0]    index,
  output logic             index_valid,
  output logic             illegal,
  output logic             seq_error,
  output logic             locked,
  output logic [7:0]       err_count
);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [IW-1:0]    LAST_IDX = IW'(2*WIDTH-1);
  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_COUNT);

  state_t       state;
  logic         have_prev;
  logic [3:0]   run;

  logic [WIDTH-1:0] norm;
  logic [WIDTH-1:0] norm_inc;
  logic             legal;
  logic [IW-1:0]    ones;
  logic [IW-1:0]    dec_idx;
  logic [IW-1:0]    succ_idx;
  logic             is_succ;
  logic [3:0]       run_next;

  // Folding codes with MSB set onto their complement turns both legal shapes
  // into an LSB run of ones, so one contiguity test covers the whole table.
  // norm never has its MSB set, so norm+1 cannot wrap.
  always_comb begin
    norm     = code[WIDTH-1] ? ~code : code;
    norm_inc = norm + ONE_W;
    legal    = ((norm & norm_inc) == '0);
    ones     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + IW'(norm[i]);
    end
    dec_idx  = code[WIDTH-1] ? (IW'(WIDTH) + ones) : ones;
  end

  // index always holds the last legal sample, so it doubles as prev.
  always_comb begin
    succ_idx = (index == LAST_IDX) ? '0 : index + IW'(1);
    is_succ  = have_prev && (dec_idx == succ_idx);
    run_next = 4'd1;
    if (is_succ) begin
      run_next = (run == 4'hF) ? 4'hF : run + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state       <= UNLOCKED;
      have_prev   <= 1'b0;
      run         <= 4'd0;
      index       <= '0;
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_error   <= 1'b0;
      locked      <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      index_valid <= 1'b0;
      illegal     <= 1'b0;
      seq_error   <= 1'b0;
      if (code_valid) begin
        if (!legal) begin
          illegal   <= 1'b1;
          state     <= UNLOCKED;
          locked    <= 1'b0;
          run       <= 4'd0;
          have_prev <= 1'b0;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else begin
          index_valid <= 1'b1;
          index       <= dec_idx;
          have_prev   <= 1'b1;
          case (state)
            LOCKED: begin
              if (!is_succ) begin
                seq_error <= 1'b1;
                state     <= UNLOCKED;
                locked    <= 1'b0;
                run       <= 4'd1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              end
            end
            default: begin
              run <= run_next;
              if (run_next >= LOCK_RUN) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// tb_johnson_decoder
//   Directed bench for johnson_decoder (WIDTH=4, LOCK_COUNT=3). A reference
//   model built from the Johnson sequence table predicts every output each
//   cycle; a few literal expectations after key steps pin the model.
module tb_johnson_decoder;

  localparam int W  = 4;
  localparam int LC = 3;
  localparam int N  = 2*W;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          clear = 1'b0;
  logic          code_valid = 1'b1;
  logic [W-1:0]  code = 4'b0001;
  logic [IW-1:0] index;
  logic          index_valid, illegal, seq_error, locked;
  logic [7:0]    err_count;

  johnson_decoder #(.WIDTH(W), .LOCK_COUNT(LC)) dut (
    .clk(clk), .clear(clear), .code_valid(code_valid), .code(code),
    .index(index), .index_valid(index_valid), .illegal(illegal),
    .seq_error(seq_error), .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Johnson table generated by the shift rule: shift left, inverted MSB in.
  logic [W-1:0] jtab [N];
  initial begin
    logic [W-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      jtab[i] = c;
      c = {c[W-2:0], ~c[W-1]};
    end
  end

  function automatic int lookup(input logic [W-1:0] c);
    for (int i = 0; i < N; i++) if (jtab[i] === c) return i;
    return -1;
  endfunction

  // Reference model
  bit model_ok = 0;
  bit m_locked, m_have;
  int m_run, m_prev, m_err;
  int e_index;
  bit e_iv, e_ill, e_seq;

  always @(posedge clk) begin
    int k;
    bit succ;
    if (!clear) begin
      m_locked = 0; m_have = 0; m_run = 0; m_prev = 0; m_err = 0;
      e_index = 0; e_iv = 0; e_ill = 0; e_seq = 0;
      model_ok = 1;
    end else begin
      e_iv = 0; e_ill = 0; e_seq = 0;
      if (code_valid) begin
        k = lookup(code);
        if (k < 0) begin
          e_ill = 1;
          if (m_err < 255) m_err++;
          m_locked = 0; m_run = 0; m_have = 0;
        end else begin
          succ = m_have && (k == (m_prev + 1) % N);
          e_iv = 1;
          e_index = k;
          if (m_locked) begin
            if (!succ) begin
              e_seq = 1;
              if (m_err < 255) m_err++;
              m_locked = 0;
              m_run = 1;
            end
          end else begin
            m_run = succ ? m_run + 1 : 1;
            if (m_run >= LC) m_locked = 1;
          end
          m_prev = k;
          m_have = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("index",       32'(index),       32'(e_index));
      chk("index_valid", 32'(index_valid), 32'(e_iv));
      chk("illegal",     32'(illegal),     32'(e_ill));
      chk("seq_error",   32'(seq_error),   32'(e_seq));
      chk("locked",      32'(locked),      32'(m_locked));
      chk("err_count",   32'(err_count),   32'(m_err));
    end
  end

  task automatic step(input logic cv, input logic [W-1:0] cd);
    code_valid = cv;
    code = cd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with a valid sample present: nothing may be emitted.
    clear = 1'b0;
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0001);
    chk("rst_index", 32'(index), 0);
    chk("rst_iv", 32'(index_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err_count), 0);

    clear = 1'b1;
    step(1'b1, 4'b0000);
    chk("first_iv", 32'(index_valid), 1);
    chk("first_locked", 32'(locked), 0);

    // Lock on third in-sequence sample, then walk through the wrap.
    step(1'b1, 4'b0001);
    chk("run2_locked", 32'(locked), 0);
    step(1'b1, 4'b0011);
    chk("lock_index", 32'(index), 2);
    chk("lock_locked", 32'(locked), 1);
    step(1'b1, 4'b0111);
    step(1'b1, 4'b1111);
    step(1'b1, 4'b1110);
    step(1'b1, 4'b1100);
    step(1'b1, 4'b1000);
    chk("idx7", 32'(index), 7);
    step(1'b1, 4'b0000);
    chk("wrap_idx", 32'(index), 0);
    chk("wrap_seq", 32'(seq_error), 0);
    chk("wrap_err", 32'(err_count), 0);

    // Illegal code while locked, then relock.
    step(1'b1, 4'b0101);
    chk("ill_pulse", 32'(illegal), 1);
    chk("ill_iv", 32'(index_valid), 0);
    chk("ill_locked", 32'(locked), 0);
    chk("ill_err", 32'(err_count), 1);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0011);
    chk("relock", 32'(locked), 1);

    // Skip 2 -> 4 breaks lock; new run seeded at 4.
    step(1'b1, 4'b1111);
    chk("skip_seq", 32'(seq_error), 1);
    chk("skip_idx", 32'(index), 4);
    chk("skip_err", 32'(err_count), 2);
    step(1'b1, 4'b1110);
    step(1'b1, 4'b1100);
    chk("skip_relock", 32'(locked), 1);

    // Idle cycles hold everything, then a repeated index is a sequence error.
    step(1'b0, 4'b0101);
    step(1'b0, 4'b0000);
    chk("idle_locked", 32'(locked), 1);
    step(1'b1, 4'b1100);
    chk("repeat_seq", 32'(seq_error), 1);
    chk("repeat_err", 32'(err_count), 3);

    // Break history, then seed at 7 and wrap across idle gaps.
    step(1'b1, 4'b1010);
    step(1'b1, 4'b1000);
    step(1'b0, 4'b0000);
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0000);
    step(1'b0, 4'b1111);
    step(1'b1, 4'b0001);
    chk("gap_lock", 32'(locked), 1);
    chk("gap_idx", 32'(index), 1);
    clear = 1'b0;
    step(1'b1, 4'b0011);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_err", 32'(err_count), 0);
    chk("midrst_iv", 32'(index_valid), 0);
    clear = 1'b1;

    // Saturation.
    for (int i = 0; i < 300; i++) step(1'b1, 4'b1010);
    chk("sat_err", 32'(err_count), 255);
    chk("sat_ill", 32'(illegal), 1);
    chk("sat_locked", 32'(locked), 0);
    step(1'b1, 4'b0000);
    chk("sat_hold", 32'(err_count), 255);
    step(1'b0, 4'b0000);
    chk("idle_ill", 32'(illegal), 0);
    clear = 1'b0;
    step(1'b1, 4'b1010);
    chk("sat_rst", 32'(err_count), 0);
    clear = 1'b1;
    step(1'b0, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
